// File: rtl/vc_test_rand_reorder_queue.sv
// vc_test_rand_reorder_queue: test-only buffer that accepts messages in order
// and re-emits them in a pseudo-random order picked by a 16-bit LFSR.
// Optional build macro VC_TEST_REORDER_STATS_EN adds arrival tags and a
// num_reordered counter output; functional behaviour is otherwise identical.

module vc_test_rand_reorder_queue #(
  parameter int unsigned p_msg_nbits   = 8,
  parameter int unsigned p_num_entries = 4,
  parameter logic [15:0] p_seed        = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_val,
  output logic                   in_rdy,
  input  logic [p_msg_nbits-1:0] in_msg,
  output logic                   out_val,
  input  logic                   out_rdy,
  output logic [p_msg_nbits-1:0] out_msg
`ifdef VC_TEST_REORDER_STATS_EN
  ,
  output logic [31:0]            num_reordered
`endif
);

  localparam int unsigned N     = p_num_entries;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [15:0] SEED  = (p_seed == 16'h0000) ? 16'hACE1 : p_seed;

  logic [N-1:0]           valid_q;
  logic [p_msg_nbits-1:0] data_q [N];
  logic [15:0]            lfsr_q;
  logic [IDX_W-1:0]       sel_q;
  logic                   lock_q;

  logic [IDX_W-1:0]       start;
  logic [IDX_W-1:0]       cand;
  logic [IDX_W-1:0]       scan_sel;
  logic [IDX_W-1:0]       sel;
  logic [IDX_W-1:0]       alloc;
  logic                   found;
  logic                   enq;
  logic                   fire;
  logic                   lfsr_fb;
  logic [N-1:0]           valid_d;

  assign start   = lfsr_q[IDX_W-1:0];
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  // Wrap-around scan for the first valid entry starting at the LFSR index
  always_comb begin
    scan_sel = '0;
    found    = 1'b0;
    cand     = '0;
    for (int k = 0; k < int'(N); k++) begin
      cand = start + IDX_W'(k);
      if (!found && valid_q[cand]) begin
        scan_sel = cand;
        found    = 1'b1;
      end
    end
  end

  // Lowest-index free entry for the next enqueue
  always_comb begin
    alloc = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      if (!valid_q[k]) alloc = IDX_W'(k);
    end
  end

  // Offer and handshake signals, derived from registered state only
  always_comb begin
    sel     = lock_q ? sel_q : scan_sel;
    out_val = |valid_q;
    out_msg = data_q[sel];
    in_rdy  = ~&valid_q;
    enq     = in_val & in_rdy;
    fire    = out_val & out_rdy;
  end

  // Next valid vector: enqueue sets a free slot, dequeue clears the offered one
  always_comb begin
    valid_d = valid_q;
    if (enq)  valid_d[alloc] = 1'b1;
    if (fire) valid_d[sel]   = 1'b0;
  end

  // Control state: valid bits, lock/selection hold, LFSR
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      lock_q  <= 1'b0;
      sel_q   <= '0;
      lfsr_q  <= SEED;
    end else begin
      valid_q <= valid_d;
      if (!lock_q) lfsr_q <= {lfsr_q[14:0], lfsr_fb};
      if (fire) begin
        lock_q <= 1'b0;
      end else if (out_val) begin
        lock_q <= 1'b1;
        sel_q  <= sel;
      end else begin
        lock_q <= 1'b0;
      end
    end
  end

  // Message storage; contents of free entries are don't-care
  always_ff @(posedge clk) begin
    if (enq) data_q[alloc] <= in_msg;
  end

`ifdef VC_TEST_REORDER_STATS_EN
  logic [31:0] tag_q [N];
  logic [31:0] enq_cnt_q;
  logic [31:0] deq_cnt_q;
  logic [31:0] num_reordered_q;

  // Arrival tags travel with each entry
  always_ff @(posedge clk) begin
    if (enq) tag_q[alloc] <= enq_cnt_q;
  end

  // Count fires whose arrival tag differs from the dequeue position
  always_ff @(posedge clk) begin
    if (reset) begin
      enq_cnt_q       <= '0;
      deq_cnt_q       <= '0;
      num_reordered_q <= '0;
    end else begin
      if (enq) enq_cnt_q <= enq_cnt_q + 32'd1;
      if (fire) begin
        deq_cnt_q <= deq_cnt_q + 32'd1;
        if (tag_q[sel] != deq_cnt_q) num_reordered_q <= num_reordered_q + 32'd1;
      end
    end
  end

  assign num_reordered = num_reordered_q;
`endif

endmodule

// File: tb/tb_vc_test_rand_reorder_queue.sv
// Directed bench for vc_test_rand_reorder_queue (default parameters).
module tb_vc_test_rand_reorder_queue;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_val;
  logic       in_rdy;
  logic [7:0] in_msg;
  logic       out_val;
  logic       out_rdy;
  logic [7:0] out_msg;
`ifdef VC_TEST_REORDER_STATS_EN
  logic [31:0] num_reordered;
`endif

  int n_vec = 0;
  int n_err = 0;

  vc_test_rand_reorder_queue #(
    .p_msg_nbits  (8),
    .p_num_entries(4),
    .p_seed       (16'hACE1)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .in_val (in_val),
    .in_rdy (in_rdy),
    .in_msg (in_msg),
    .out_val(out_val),
    .out_rdy(out_rdy),
    .out_msg(out_msg)
`ifdef VC_TEST_REORDER_STATS_EN
    ,
    .num_reordered(num_reordered)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    in_val  = 1'b0;
    in_msg  = 8'h00;
    out_rdy = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  logic any_reordered = 1'b0;

  // Stream 64 messages with fixed source/sink duty patterns; check each fire is fresh
  task automatic stream(input int src_per, input int snk_per);
    logic [63:0] seen;
    int next_in;
    int n_out;
    int cyc;
    logic acc;
    seen    = '0;
    next_in = 0;
    n_out   = 0;
    cyc     = 0;
    while (n_out < 64 && cyc < 5000) begin
      in_val  = (next_in < 64) && ((cyc % src_per) == 0);
      in_msg  = 8'(next_in);
      out_rdy = ((cyc % snk_per) == 0);
      acc     = in_val && in_rdy;
      if (out_val && out_rdy) begin
        check("stream_fresh", {30'd0, out_msg >= 8'd64, seen[out_msg[5:0]]}, 32'd0);
        if (out_msg != 8'(n_out)) any_reordered = 1'b1;
        seen[out_msg[5:0]] = 1'b1;
        n_out++;
      end
      step();
      if (acc) next_in++;
      cyc++;
    end
    in_val  = 1'b0;
    out_rdy = 1'b0;
    check("stream_count", 32'(n_out), 32'd64);
    check("stream_all_seen", {31'd0, &seen}, 32'd1);
    check("stream_empty", {31'd0, out_val}, 32'd0);
  endtask

  initial begin
    // Reset then idle
    do_reset();
    check("rst_out_val", {31'd0, out_val}, 32'd0);
    check("rst_in_rdy", {31'd0, in_rdy}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("idle_out_val", {31'd0, out_val}, 32'd0);
      check("idle_in_rdy", {31'd0, in_rdy}, 32'd1);
    end

    // Fill right after reset so the LFSR sequence is known: drain order 01,04,02,03
    do_reset();
    in_val = 1'b1;
    in_msg = 8'h01;
    step();
    check("fill1_out_val", {31'd0, out_val}, 32'd1);
    check("fill1_out_msg", 32'(out_msg), 32'h01);
    check("fill1_in_rdy", {31'd0, in_rdy}, 32'd1);
    in_msg = 8'h02;
    step();
    in_msg = 8'h03;
    step();
    in_msg = 8'h04;
    step();
    check("full_in_rdy", {31'd0, in_rdy}, 32'd0);
    in_msg = 8'h05;
    for (int i = 0; i < 10; i++) begin
      check("hold_out_val", {31'd0, out_val}, 32'd1);
      check("hold_out_msg", 32'(out_msg), 32'h01);
      check("hold_in_rdy", {31'd0, in_rdy}, 32'd0);
      step();
    end
    in_val  = 1'b0;
    out_rdy = 1'b1;
    check("drain0_msg", 32'(out_msg), 32'h01);
    step();
    check("drain1_val", {31'd0, out_val}, 32'd1);
    check("drain1_msg", 32'(out_msg), 32'h04);
    step();
    check("drain2_msg", 32'(out_msg), 32'h02);
    step();
    check("drain3_msg", 32'(out_msg), 32'h03);
    step();
    check("drained_out_val", {31'd0, out_val}, 32'd0);
    check("drained_in_rdy", {31'd0, in_rdy}, 32'd1);
`ifdef VC_TEST_REORDER_STATS_EN
    check("fill_num_reordered", num_reordered, 32'd3);
`endif

    // Single message into empty queue with sink ready
    out_rdy = 1'b1;
    in_val  = 1'b1;
    in_msg  = 8'hAA;
    check("aa_pre_out_val", {31'd0, out_val}, 32'd0);
    step();
    in_val = 1'b0;
    check("aa_out_val", {31'd0, out_val}, 32'd1);
    check("aa_out_msg", 32'(out_msg), 32'hAA);
    step();
    check("aa_empty", {31'd0, out_val}, 32'd0);
    check("aa_in_rdy", {31'd0, in_rdy}, 32'd1);
    out_rdy = 1'b0;

    // Streaming with several source/sink duty patterns
    stream(1, 1);
    stream(3, 3);
    stream(1, 4);
    stream(11, 4);
    check("reordered_once", {31'd0, any_reordered}, 32'd1);
`ifdef VC_TEST_REORDER_STATS_EN
    check("stream_num_reordered_nz", {31'd0, num_reordered != 32'd0}, 32'd1);
`endif

    // Reset with two entries buffered and an offer locked
    in_val  = 1'b1;
    out_rdy = 1'b0;
    in_msg  = 8'h11;
    step();
    in_msg = 8'h22;
    step();
    in_val = 1'b0;
    check("mid_out_val", {31'd0, out_val}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_out_val", {31'd0, out_val}, 32'd0);
    check("mid_rst_in_rdy", {31'd0, in_rdy}, 32'd1);
`ifdef VC_TEST_REORDER_STATS_EN
    check("mid_rst_num_reordered", num_reordered, 32'd0);
`endif
    out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_rst_out_val", {31'd0, out_val}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vc_test_rand_reorder_queue.md
Name: vc_test_rand_reorder_queue

Overview:
- Test-only buffering stage that sits between a random-delay test source and an unordered test sink.
- Accepts messages in order over val/rdy and holds up to p_num_entries of them.
- Emits them in a pseudo-random order chosen by an internal LFSR.
- Used to exercise consumers that must tolerate out-of-order delivery, and to check that the unordered sink accepts any permutation of the expected message set.

Parameters:
- p_msg_nbits, 8, message width in bits
- p_num_entries, 4, buffer depth; power of two, 2..16
- p_seed, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'hACE1

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- in_val  input  1  upstream message valid
- in_rdy  output  1  queue can accept a message
- in_msg  input  p_msg_nbits  upstream message
- out_val  output  1  a message is offered downstream
- out_rdy  input  1  downstream accepts
- out_msg  output  p_msg_nbits  offered message

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high on reset.
- State:
  - valid[N] and data[N] entry arrays.
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting left, feedback into bit 0.
  - sel_q: index of the entry currently offered.
  - lock_q: offer is pending and must stay stable.
- Reset:
  - all valid=0, lock_q=0, sel_q=0, LFSR=p_seed (substituted if 0).
  - Outputs after reset: out_val=0, in_rdy=1, out_msg=data[0] (don't care).
- Enqueue:
  - in_rdy = OR of ~valid[i], computed combinationally from registered state only. No combinational path from out_rdy to in_rdy.
  - On in_val && in_rdy, write in_msg into the lowest-index free entry and set its valid bit.
  - Minimum latency in->out is 1 cycle; there is no bypass when empty.
- Selection, when lock_q=0:
  - start = LFSR[log2(N)-1:0].
  - sel = first index with valid set, scanning start, start+1, ... modulo N (wrap-around).
  - out_val = OR of valid[i].
- Selection, when lock_q=1: sel = sel_q. out_val=1 and out_msg=data[sel_q] are guaranteed unchanged.
- Dequeue: on out_val && out_rdy, clear valid[sel]; lock_q goes to 0.
- Lock: if out_val && !out_rdy, set lock_q=1 and sel_q=sel at the edge.
- LFSR:
  - advances every cycle where lock_q=0 at the edge, whether or not a dequeue occurs.
  - holds while lock_q=1.
- Simultaneous enqueue and dequeue:
  - both take effect at the same edge.
  - a slot freed by the dequeue is not usable by the same-cycle enqueue; in_rdy reflects pre-edge state.
- Full: in_rdy=0; in_val is ignored.
- Empty: out_val=0; out_msg is don't care; lock_q stays 0.
- Reset asserted mid-operation: all buffered messages are discarded and the LFSR is reseeded at the next edge, regardless of the handshake state.
- Message conservation: every accepted message is emitted exactly once. No loss, no duplication.

Optional Feature:
- Macro: VC_TEST_REORDER_STATS_EN.
- When defined:
  - adds output port num_reordered (32 bits).
  - each entry stores a 32-bit arrival tag taken from a wrapping enqueue counter.
  - a 32-bit dequeue counter counts fires.
  - on each fire where the emitted tag != dequeue counter, num_reordered increments by 1.
  - all counters reset to 0.
- When not defined: the port, tags and counters are absent. Functional behaviour is identical.

Test Plan:
- Reset, then idle 5 cycles -> out_val=0, in_rdy=1 throughout; no message emitted.
- Push 0x01..0x04 back-to-back with out_rdy=0 -> in_rdy drops to 0 after 4th accept; 0x05 is not accepted while full.
- Fill with 0x01..0x04, then hold out_rdy=0 for 10 cycles -> out_val=1 and out_msg constant across all 10 cycles; after out_rdy=1 the same value fires.
- Stream 0x00..0x3F (64 msgs) through source/sink with max delays 0/0, 2/2, 10/3 into an unordered sink -> sink reports num_failed=0 and done=1 within 5000 cycles; the emitted sequence differs from arrival order at least once.
- Enqueue 0xAA into an empty queue while out_rdy=1 -> out_val first asserted the cycle after accept; 0xAA fires then; the queue returns to empty.
- With VC_TEST_REORDER_STATS_EN, p_seed=16'hACE1: run the 64-msg stream, then reset mid-stream with 2 entries buffered -> num_reordered>0 before the reset; after the reset, out_val=0, in_rdy=1, num_reordered=0.
